bp_cce_inst_fetch: RTL and testbench

- Fetch stage of the CCE microcode engine.
- Owns the fetch PC register and the synchronous-read instruction RAM.
- Presents the RAM read data and the registered PC to the instruction pre-decoder, and takes back the pre-decoder's predicted next PC.
- Delivers valid instructions to decode with a valid/ready handshake, applies execute-stage mispredict redirects, and supports RAM loading in config mode.

---
 rtl/bp_cce_inst_fetch.sv | 145 ++++++++++++++
 tb/tb_bp_cce_inst_fetch.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cce_inst_fetch.sv
// CCE microcode fetch stage: fetch PC, synchronous instruction RAM, valid/ready delivery to decode.
// Optional mispredict counter enabled by defining BP_CCE_FETCH_MISPREDICT_CNT_EN.
module bp_cce_inst_fetch #(
    parameter int unsigned inst_ram_els_p = 256,
    parameter int unsigned inst_width_p   = 48,
    parameter int unsigned pc_width_p     = $clog2(inst_ram_els_p)
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    cfg_mode_i,
    input  logic                    cfg_w_v_i,
    input  logic [pc_width_p-1:0]   cfg_addr_i,
    input  logic [inst_width_p-1:0] cfg_data_i,
    output logic [inst_width_p-1:0] predecode_inst_o,
    output logic [pc_width_p-1:0]   predecode_pc_o,
    input  logic [pc_width_p-1:0]   predicted_next_pc_i,
    output logic                    inst_v_o,
    output logic [inst_width_p-1:0] inst_o,
    output logic [pc_width_p-1:0]   inst_pc_o,
    input  logic                    inst_ready_i,
    input  logic                    mispredict_v_i,
    input  logic [pc_width_p-1:0]   mispredict_pc_i,
    output logic [15:0]             mispredict_count_o
);

    typedef enum logic [1:0] {
        e_init  = 2'd0,
        e_prime = 2'd1,
        e_fetch = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [pc_width_p-1:0]   pc_q, pc_d;
    logic                    inst_v_q, inst_v_d;
    logic [inst_width_p-1:0] ram_data_q;
    logic [inst_width_p-1:0] mem [inst_ram_els_p];

    logic                    ram_rd_v;
    logic [pc_width_p-1:0]   ram_rd_addr;
    logic                    ram_w_v;
    logic                    stall;

    // Next-PC mux and state transitions; in FETCH with inst_v_q low we are in a kill bubble
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_v_d    = 1'b0;
        ram_rd_v    = 1'b0;
        ram_rd_addr = pc_q;
        ram_w_v     = 1'b0;
        stall       = inst_v_q & ~inst_ready_i;

        case (state_q)
            e_init: begin
                ram_w_v = cfg_w_v_i & reset_n_i;
                if (!cfg_mode_i) begin
                    state_d     = e_prime;
                    pc_d        = '0;
                    ram_rd_v    = 1'b1;
                    ram_rd_addr = '0;
                end
            end
            e_prime: begin
                state_d     = e_fetch;
                inst_v_d    = 1'b1;
                ram_rd_v    = 1'b1;
                ram_rd_addr = pc_q;
            end
            e_fetch: begin
                if (cfg_mode_i) begin
                    state_d = e_init;
                    pc_d    = '0;
                end else if (mispredict_v_i) begin
                    pc_d        = mispredict_pc_i;
                    ram_rd_v    = 1'b1;
                    ram_rd_addr = mispredict_pc_i;
                end else if (!inst_v_q || stall) begin
                    // Bubble end or stall: hold PC and RAM output
                    inst_v_d = 1'b1;
                end else begin
                    pc_d        = predicted_next_pc_i;
                    ram_rd_v    = 1'b1;
                    ram_rd_addr = predicted_next_pc_i;
                    inst_v_d    = 1'b1;
                end
            end
            default: begin
                state_d = e_init;
                pc_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q  <= e_init;
            pc_q     <= '0;
            inst_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_v_q <= inst_v_d;
        end
    end

    // Synchronous-read instruction RAM; contents survive reset
    always_ff @(posedge clk_i) begin
        if (ram_w_v) begin
            mem[cfg_addr_i] <= cfg_data_i;
        end
        if (ram_rd_v && reset_n_i) begin
            ram_data_q <= mem[ram_rd_addr];
        end
    end

`ifdef BP_CCE_FETCH_MISPREDICT_CNT_EN
    logic [15:0] mp_cnt_q, mp_cnt_d;

    always_comb begin
        mp_cnt_d = mp_cnt_q;
        if ((state_q == e_fetch) && mispredict_v_i && (mp_cnt_q != 16'hFFFF)) begin
            mp_cnt_d = mp_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            mp_cnt_q <= '0;
        end else begin
            mp_cnt_q <= mp_cnt_d;
        end
    end

    assign mispredict_count_o = mp_cnt_q;
`else
    assign mispredict_count_o = 16'd0;
`endif

    assign predecode_inst_o = ram_data_q;
    assign predecode_pc_o   = pc_q;
    assign inst_o           = ram_data_q;
    assign inst_pc_o        = pc_q;
    assign inst_v_o         = inst_v_q;

endmodule

// File: tb/tb_bp_cce_inst_fetch.sv
// Bench for bp_cce_inst_fetch: directed stimulus, cycle-level reference model, literal spot checks.
module tb_bp_cce_inst_fetch;

    localparam int unsigned PC_W   = 8;
    localparam int unsigned INST_W = 48;

    logic              clk = 1'b0;
    logic              reset_n_i = 1'b0;
    logic              cfg_mode_i = 1'b1;
    logic              cfg_w_v_i = 1'b0;
    logic [PC_W-1:0]   cfg_addr_i = '0;
    logic [INST_W-1:0] cfg_data_i = '0;
    logic [INST_W-1:0] predecode_inst_o;
    logic [PC_W-1:0]   predecode_pc_o;
    logic [PC_W-1:0]   predicted_next_pc_i;
    logic              inst_v_o;
    logic [INST_W-1:0] inst_o;
    logic [PC_W-1:0]   inst_pc_o;
    logic              inst_ready_i = 1'b0;
    logic              mispredict_v_i = 1'b0;
    logic [PC_W-1:0]   mispredict_pc_i = '0;
    logic [15:0]       mispredict_count_o;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    // Pre-decoder stand-in: sequential next PC, wrapping at the RAM depth
    assign predicted_next_pc_i = predecode_pc_o + 8'd1;

    bp_cce_inst_fetch dut (
        .clk_i              (clk),
        .reset_n_i          (reset_n_i),
        .cfg_mode_i         (cfg_mode_i),
        .cfg_w_v_i          (cfg_w_v_i),
        .cfg_addr_i         (cfg_addr_i),
        .cfg_data_i         (cfg_data_i),
        .predecode_inst_o   (predecode_inst_o),
        .predecode_pc_o     (predecode_pc_o),
        .predicted_next_pc_i(predicted_next_pc_i),
        .inst_v_o           (inst_v_o),
        .inst_o             (inst_o),
        .inst_pc_o          (inst_pc_o),
        .inst_ready_i       (inst_ready_i),
        .mispredict_v_i     (mispredict_v_i),
        .mispredict_pc_i    (mispredict_pc_i),
        .mispredict_count_o (mispredict_count_o)
    );

    function automatic logic [INST_W-1:0] inst_val(int i);
        return {24'hCCE000, 16'(i * 3), 8'(i)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: tracks whether fetch is running, cycles of invalid output still owed, and the PC shown
    logic [INST_W-1:0] m_mem [256];
    bit                m_active = 1'b0;
    bit                m_prime  = 1'b0;
    bit                m_wait   = 1'b0;
    logic [PC_W-1:0]   m_pc     = '0;
    logic [15:0]       m_cnt    = '0;

    always @(posedge clk) begin
        if (!reset_n_i) begin
            m_active = 1'b0;
            m_prime  = 1'b0;
            m_wait   = 1'b0;
            m_pc     = '0;
            m_cnt    = '0;
        end else if (!m_active) begin
            if (cfg_w_v_i) m_mem[cfg_addr_i] = cfg_data_i;
            if (!cfg_mode_i) begin
                m_active = 1'b1;
                m_prime  = 1'b1;
                m_pc     = '0;
            end
        end else if (m_prime) begin
            m_prime = 1'b0;
        end else begin
`ifdef BP_CCE_FETCH_MISPREDICT_CNT_EN
            if (mispredict_v_i && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
            if (cfg_mode_i) begin
                m_active = 1'b0;
                m_wait   = 1'b0;
                m_pc     = '0;
            end else if (mispredict_v_i) begin
                m_pc   = mispredict_pc_i;
                m_wait = 1'b1;
            end else if (m_wait) begin
                m_wait = 1'b0;
            end else if (inst_ready_i) begin
                m_pc = m_pc + 8'd1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            automatic bit exp_v = m_active && !m_prime && !m_wait;
            chk("model_inst_v", 64'(inst_v_o), 64'(exp_v));
            chk("model_predecode_pc", 64'(predecode_pc_o), 64'(m_pc));
            chk("model_count", 64'(mispredict_count_o), 64'(m_cnt));
            if (exp_v) begin
                chk("model_inst_pc", 64'(inst_pc_o), 64'(m_pc));
                chk("model_inst", 64'(inst_o), 64'(m_mem[m_pc]));
                chk("model_predecode_inst", 64'(predecode_inst_o), 64'(m_mem[m_pc]));
            end
        end
    end

    initial begin
        logic [39:0] ready_pat;
        ready_pat = 40'hB6_D3_5A_F0_9C;

        tick();
        tick();
        reset_n_i = 1'b1;
        chk("reset_inst_v", 64'(inst_v_o), 64'd0);
        chk("reset_count", 64'(mispredict_count_o), 64'd0);
        chk("reset_pc", 64'(predecode_pc_o), 64'd0);
        chk_en = 1'b1;

        // Load the whole RAM in config mode
        cfg_mode_i = 1'b1;
        for (int i = 0; i < 256; i++) begin
            cfg_w_v_i  = 1'b1;
            cfg_addr_i = 8'(i);
            cfg_data_i = inst_val(i);
            tick();
            chk("init_inst_v", 64'(inst_v_o), 64'd0);
        end
        cfg_w_v_i = 1'b0;

        // Leave INIT: two invalid cycles, then PC 0,1,2
        cfg_mode_i   = 1'b0;
        inst_ready_i = 1'b1;
        tick();
        chk("prime_inst_v", 64'(inst_v_o), 64'd0);
        tick();
        chk("first_v", 64'(inst_v_o), 64'd1);
        chk("first_pc", 64'(inst_pc_o), 64'd0);
        chk("first_inst", 64'(inst_o), 64'(inst_val(0)));
        tick();
        chk("pc1", 64'(inst_pc_o), 64'd1);
        tick();
        chk("pc2", 64'(inst_pc_o), 64'd2);

        // Stall three cycles at PC 2
        inst_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_v", 64'(inst_v_o), 64'd1);
            chk("stall_pc", 64'(inst_pc_o), 64'd2);
            chk("stall_inst", 64'(inst_o), 64'(inst_val(2)));
        end
        inst_ready_i = 1'b1;
        tick();
        chk("after_stall_pc", 64'(inst_pc_o), 64'd3);
        tick();
        tick();
        chk("pc5", 64'(inst_pc_o), 64'd5);

        // Mispredict concurrent with a stall
        inst_ready_i    = 1'b0;
        mispredict_v_i  = 1'b1;
        mispredict_pc_i = 8'h40;
        tick();
        chk("kill_bubble_v", 64'(inst_v_o), 64'd0);
        mispredict_v_i = 1'b0;
        inst_ready_i   = 1'b1;
        tick();
        chk("redirect_v", 64'(inst_v_o), 64'd1);
        chk("redirect_pc", 64'(inst_pc_o), 64'h40);
        chk("redirect_inst", 64'(inst_o), 64'(inst_val(8'h40)));

        // PC wrap through 0xFF
        mispredict_v_i  = 1'b1;
        mispredict_pc_i = 8'hFE;
        tick();
        mispredict_v_i = 1'b0;
        tick();
        tick();
        chk("pc_ff", 64'(inst_pc_o), 64'hFF);
        tick();
        chk("wrap_pc", 64'(inst_pc_o), 64'd0);
        chk("wrap_inst", 64'(inst_o), 64'(inst_val(0)));

        // Config write while fetching is ignored
        cfg_w_v_i  = 1'b1;
        cfg_addr_i = 8'd3;
        cfg_data_i = 48'hDEAD_BEEF_0000;
        tick();
        cfg_w_v_i = 1'b0;
        tick();
        tick();
        chk("fetch_cfg_ignored_pc", 64'(inst_pc_o), 64'd3);
        chk("fetch_cfg_ignored_inst", 64'(inst_o), 64'(inst_val(3)));

        // Back-to-back mispredicts: latest wins
        mispredict_v_i  = 1'b1;
        mispredict_pc_i = 8'h10;
        tick();
        mispredict_pc_i = 8'h20;
        tick();
        chk("b2b_bubble_v", 64'(inst_v_o), 64'd0);
        mispredict_v_i = 1'b0;
        tick();
        chk("b2b_pc", 64'(inst_pc_o), 64'h20);
        chk("b2b_inst", 64'(inst_o), 64'(inst_val(8'h20)));
`ifdef BP_CCE_FETCH_MISPREDICT_CNT_EN
        chk("count_4", 64'(mispredict_count_o), 64'd4);
`else
        chk("count_tied_0", 64'(mispredict_count_o), 64'd0);
`endif

        // Reset during a stall with a pending mispredict
        inst_ready_i = 1'b0;
        tick();
        reset_n_i       = 1'b0;
        mispredict_v_i  = 1'b1;
        mispredict_pc_i = 8'h30;
        tick();
        reset_n_i      = 1'b1;
        mispredict_v_i = 1'b0;
        cfg_mode_i     = 1'b1;
        chk("midreset_v", 64'(inst_v_o), 64'd0);
        chk("midreset_count", 64'(mispredict_count_o), 64'd0);
        chk("midreset_pc", 64'(predecode_pc_o), 64'd0);
        cfg_w_v_i  = 1'b1;
        cfg_addr_i = 8'd3;
        cfg_data_i = 48'h1234_5678_9ABC;
        tick();
        cfg_w_v_i    = 1'b0;
        cfg_mode_i   = 1'b0;
        inst_ready_i = 1'b1;
        tick();
        tick();
        chk("restart_pc0", 64'(inst_pc_o), 64'd0);
        tick();
        tick();
        tick();
        chk("init_write_pc", 64'(inst_pc_o), 64'd3);
        chk("init_write_inst", 64'(inst_o), 64'h1234_5678_9ABC);

        // Config mode while fetching returns to INIT
        cfg_mode_i = 1'b1;
        tick();
        chk("cfg_exit_v", 64'(inst_v_o), 64'd0);
        chk("cfg_exit_pc", 64'(predecode_pc_o), 64'd0);
        cfg_mode_i = 1'b0;
        tick();
        tick();
        chk("refetch_v", 64'(inst_v_o), 64'd1);
        chk("refetch_pc", 64'(inst_pc_o), 64'd0);

        // Irregular ready pattern, checked by the model
        for (int k = 0; k < 40; k++) begin
            inst_ready_i = ready_pat[k];
            tick();
        end
        inst_ready_i = 1'b1;

`ifdef BP_CCE_FETCH_MISPREDICT_CNT_EN
        // Drive the counter into saturation
        mispredict_v_i  = 1'b1;
        mispredict_pc_i = 8'h00;
        for (int k = 0; k < 65540; k++) tick();
        mispredict_v_i = 1'b0;
        chk("count_saturated", 64'(mispredict_count_o), 64'hFFFF);
        tick();
`endif

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
